// File: rtl/bel_fft_pkg.sv
// Shared types, constants and sizing helpers for the belfft CMAC datapath.
// No logic of its own; used by the pipelined CMAC and the rounding/saturation stage.
// No flow control here; handshaking lives in the modules that import it.
package bel_fft_pkg;

    localparam int CMAC_WIDTH   = 16;
    localparam int CMAC_LATENCY = 3;

    typedef struct packed {
        logic conj;
        logic sub;
    } cmac_ctl_t;

    // Accumulator width: holds a*2^FRAC, the full product sum and the rounding bias without loss.
    function automatic int sum_width(input int w, input int frac);
        return (((w + frac) > (2 * w)) ? (w + frac) : (2 * w)) + 2;
    endfunction

endpackage

// File: rtl/bel_round_sat.sv
// Drops FRAC fraction bits (arithmetic shift) and clamps or wraps into OUT_W bits, flagging overflow.
// Latency: combinational.
// Backpressure: none, pure function of its input.
module bel_round_sat #(
    parameter int IN_W     = 34,
    parameter int OUT_W    = 16,
    parameter int FRAC     = 15,
    parameter int SATURATE = 1
) (
    input  logic signed [IN_W-1:0]  sum,
    output logic signed [OUT_W-1:0] res,
    output logic                    ovf
);

    localparam logic signed [IN_W-1:0] MAXV = (IN_W'(1) << (OUT_W - 1)) - IN_W'(1);
    localparam logic signed [IN_W-1:0] MINV = ~MAXV;

    logic signed [IN_W-1:0] sh;
    logic                   hi;
    logic                   lo;

    // Rounding bias was already added upstream, so a plain floor shift completes round-half-up.
    assign sh  = sum >>> FRAC;
    assign hi  = (sh > MAXV);
    assign lo  = (sh < MINV);
    assign ovf = hi | lo;

    generate
        if (SATURATE != 0) begin : g_sat
            assign res = hi ? MAXV[OUT_W-1:0] : (lo ? MINV[OUT_W-1:0] : sh[OUT_W-1:0]);
        end else begin : g_wrap
            assign res = sh[OUT_W-1:0];
        end
    endgenerate

endmodule

// File: rtl/bel_cmac_pipe.sv
// Pipelined complex MAC x = a +/- b*c (optionally conj(c)), round-half-up, saturate or wrap.
// Latency: 3 cycles input transfer to valid_o; one operand set per cycle.
// Backpressure: global stall, all stages hold while valid_o && !ready_i; ready_o = !valid_o || ready_i.
module bel_cmac_pipe
    import bel_fft_pkg::*;
#(
    parameter int WIDTH    = CMAC_WIDTH,
    parameter int FRAC     = WIDTH - 1,
    parameter int SATURATE = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic signed [WIDTH-1:0] a_re_i,
    input  logic signed [WIDTH-1:0] a_im_i,
    input  logic signed [WIDTH-1:0] b_re_i,
    input  logic signed [WIDTH-1:0] b_im_i,
    input  logic signed [WIDTH-1:0] c_re_i,
    input  logic signed [WIDTH-1:0] c_im_i,
    input  logic                    conj_i,
    input  logic                    sub_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic signed [WIDTH-1:0] x_re_o,
    output logic signed [WIDTH-1:0] x_im_o,
    output logic                    ovf_o
);

    localparam int PW = 2 * WIDTH;
    localparam int SW = sum_width(WIDTH, FRAC);
    localparam logic signed [SW-1:0] RND = SW'(1) << (FRAC - 1);

    logic en;

    assign en      = !valid_o || ready_i;
    assign ready_o = en;

    // S1: operand capture and the four partial products
    logic                    s1_vld;
    cmac_ctl_t               s1_ctl;
    logic signed [WIDTH-1:0] s1_a_re;
    logic signed [WIDTH-1:0] s1_a_im;
    logic signed [PW-1:0]    s1_rr;
    logic signed [PW-1:0]    s1_ii;
    logic signed [PW-1:0]    s1_ri;
    logic signed [PW-1:0]    s1_ir;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_vld <= 1'b0;
        end else if (en) begin
            s1_vld <= valid_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (en && valid_i) begin
            s1_ctl  <= '{conj: conj_i, sub: sub_i};
            s1_a_re <= a_re_i;
            s1_a_im <= a_im_i;
            s1_rr   <= PW'(b_re_i) * PW'(c_re_i);
            s1_ii   <= PW'(b_im_i) * PW'(c_im_i);
            s1_ri   <= PW'(b_re_i) * PW'(c_im_i);
            s1_ir   <= PW'(b_im_i) * PW'(c_re_i);
        end
    end

    // S2: conjugation is applied as a sign choice here so c_im = -2^(WIDTH-1) stays exact
    logic signed [SW-1:0] p_re;
    logic signed [SW-1:0] p_im;
    logic signed [SW-1:0] a_re_sh;
    logic signed [SW-1:0] a_im_sh;
    logic signed [SW-1:0] s_re_nxt;
    logic signed [SW-1:0] s_im_nxt;

    always_comb begin
        p_re     = s1_ctl.conj ? (SW'(s1_rr) + SW'(s1_ii)) : (SW'(s1_rr) - SW'(s1_ii));
        p_im     = s1_ctl.conj ? (SW'(s1_ir) - SW'(s1_ri)) : (SW'(s1_ri) + SW'(s1_ir));
        a_re_sh  = SW'(s1_a_re) <<< FRAC;
        a_im_sh  = SW'(s1_a_im) <<< FRAC;
        s_re_nxt = s1_ctl.sub ? (a_re_sh - p_re + RND) : (a_re_sh + p_re + RND);
        s_im_nxt = s1_ctl.sub ? (a_im_sh - p_im + RND) : (a_im_sh + p_im + RND);
    end

    logic                 s2_vld;
    logic signed [SW-1:0] s2_re;
    logic signed [SW-1:0] s2_im;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s2_vld <= 1'b0;
        end else if (en) begin
            s2_vld <= s1_vld;
        end
    end

    always_ff @(posedge clk_i) begin
        if (en && s1_vld) begin
            s2_re <= s_re_nxt;
            s2_im <= s_im_nxt;
        end
    end

    // S3: scale back, clamp/wrap, register the result
    logic signed [WIDTH-1:0] r_re;
    logic signed [WIDTH-1:0] r_im;
    logic                    ovf_re;
    logic                    ovf_im;

    bel_round_sat #(
        .IN_W     (SW),
        .OUT_W    (WIDTH),
        .FRAC     (FRAC),
        .SATURATE (SATURATE)
    ) u_rs_re (
        .sum (s2_re),
        .res (r_re),
        .ovf (ovf_re)
    );

    bel_round_sat #(
        .IN_W     (SW),
        .OUT_W    (WIDTH),
        .FRAC     (FRAC),
        .SATURATE (SATURATE)
    ) u_rs_im (
        .sum (s2_im),
        .res (r_im),
        .ovf (ovf_im)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            ovf_o   <= 1'b0;
            x_re_o  <= '0;
            x_im_o  <= '0;
        end else if (en) begin
            valid_o <= s2_vld;
            if (s2_vld) begin
                ovf_o  <= ovf_re | ovf_im;
                x_re_o <= r_re;
                x_im_o <= r_im;
            end
        end
    end

endmodule

// File: tb/tb_bel_cmac_pipe.sv
// Scoreboard bench for bel_cmac_pipe: saturating and wrapping instances share one input stream.
module tb_bel_cmac_pipe;
    import bel_fft_pkg::*;

    localparam int W = CMAC_WIDTH;
    localparam longint H = longint'(1) <<< (W - 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic valid_i, ready_i, conj_i, sub_i;
    logic signed [W-1:0] a_re_i, a_im_i, b_re_i, b_im_i, c_re_i, c_im_i;
    logic s_ready, s_valid, s_ovf, w_ready, w_valid, w_ovf;
    logic signed [W-1:0] s_re, s_im, w_re, w_im;

    bel_cmac_pipe #(.WIDTH(W), .FRAC(W - 1), .SATURATE(1)) u_sat (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(s_ready),
        .a_re_i(a_re_i), .a_im_i(a_im_i), .b_re_i(b_re_i), .b_im_i(b_im_i),
        .c_re_i(c_re_i), .c_im_i(c_im_i), .conj_i(conj_i), .sub_i(sub_i),
        .valid_o(s_valid), .ready_i(ready_i), .x_re_o(s_re), .x_im_o(s_im), .ovf_o(s_ovf)
    );

    bel_cmac_pipe #(.WIDTH(W), .FRAC(W - 1), .SATURATE(0)) u_wrap (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(w_ready),
        .a_re_i(a_re_i), .a_im_i(a_im_i), .b_re_i(b_re_i), .b_im_i(b_im_i),
        .c_re_i(c_re_i), .c_im_i(c_im_i), .conj_i(conj_i), .sub_i(sub_i),
        .valid_o(w_valid), .ready_i(ready_i), .x_re_o(w_re), .x_im_o(w_im), .ovf_o(w_ovf)
    );

    typedef struct {
        longint a_re, a_im, b_re, b_im, c_re, c_im;
        bit     conj, sub;
        bit     has_exp;
        longint e_re, e_im;
        bit     e_ovf;
    } op_t;

    typedef struct {
        longint re, im;
        bit     ovf;
        int     stamp;
        bit     lat;
    } exp_t;

    exp_t q_sat[$];
    exp_t q_wrap[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    bit   s_held = 0, w_held = 0;
    longint hs_re, hs_im, hw_re, hw_im;
    bit   hs_ovf, hw_ovf;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic longint scale(input longint s, input bit sat, inout bit ovf);
        longint r;
        r = s >>> (W - 1);
        if (r > H - 1 || r < -H) begin
            ovf = 1'b1;
            if (sat) r = (r > 0) ? H - 1 : -H;
            else     r = ((r + H) & (2 * H - 1)) - H;
        end
        return r;
    endfunction

    // Golden model: b*conj(c) written via the negated imaginary part of c.
    function automatic exp_t model(input op_t o, input bit sat);
        exp_t   e;
        longint ce, pre, pim, sre, sim, bias;
        bit     ov;
        ce   = o.conj ? -o.c_im : o.c_im;
        pre  = o.b_re * o.c_re - o.b_im * ce;
        pim  = o.b_re * ce + o.b_im * o.c_re;
        bias = longint'(1) <<< (W - 2);
        sre  = o.a_re * (longint'(1) <<< (W - 1)) + (o.sub ? -pre : pre) + bias;
        sim  = o.a_im * (longint'(1) <<< (W - 1)) + (o.sub ? -pim : pim) + bias;
        ov   = 1'b0;
        e.re  = scale(sre, sat, ov);
        e.im  = scale(sim, sat, ov);
        e.ovf = ov;
        e.stamp = 0;
        e.lat = 1'b0;
        return e;
    endfunction

    // One cycle: drive at the falling edge, then observe both instances before the next rising edge.
    task automatic step(input bit v, input op_t o, input bit rdy, input bit lat, output bit acc);
        exp_t e;
        @(negedge clk);
        valid_i = v;  ready_i = rdy;
        a_re_i = W'(o.a_re); a_im_i = W'(o.a_im);
        b_re_i = W'(o.b_re); b_im_i = W'(o.b_im);
        c_re_i = W'(o.c_re); c_im_i = W'(o.c_im);
        conj_i = o.conj; sub_i = o.sub;
        #1;
        cyc++;
        if (s_held) begin
            chk("stall_hold_vld", s_valid, 1);
            chk("stall_hold_re", s_re, hs_re);
            chk("stall_hold_im", s_im, hs_im);
            chk("stall_hold_ovf", s_ovf, hs_ovf);
        end
        if (w_held) begin
            chk("stall_hold_w_re", w_re, hw_re);
            chk("stall_hold_w_ovf", w_ovf, hw_ovf);
        end
        s_held = 0;
        w_held = 0;
        if (s_valid && ready_i) begin
            if (q_sat.size() == 0) chk("spurious_sat", 1, 0);
            else begin
                e = q_sat.pop_front();
                chk("sat_re", s_re, e.re);
                chk("sat_im", s_im, e.im);
                chk("sat_ovf", s_ovf, e.ovf);
                if (e.lat) chk("latency", cyc - e.stamp, CMAC_LATENCY);
            end
        end else if (s_valid) begin
            s_held = 1; hs_re = s_re; hs_im = s_im; hs_ovf = s_ovf;
            chk("stall_ready", s_ready, 0);
        end
        if (w_valid && ready_i) begin
            if (q_wrap.size() == 0) chk("spurious_wrap", 1, 0);
            else begin
                e = q_wrap.pop_front();
                chk("wrap_re", w_re, e.re);
                chk("wrap_im", w_im, e.im);
                chk("wrap_ovf", w_ovf, e.ovf);
            end
        end else if (w_valid) begin
            w_held = 1; hw_re = w_re; hw_im = w_im; hw_ovf = w_ovf;
            chk("stall_ready_w", w_ready, 0);
        end
        acc = v && s_ready;
        if (acc) begin
            e = o.has_exp ? '{re: o.e_re, im: o.e_im, ovf: o.e_ovf, stamp: 0, lat: 1'b0}
                          : model(o, 1'b1);
            e.stamp = cyc; e.lat = lat;
            q_sat.push_back(e);
            e = model(o, 1'b0);
            e.stamp = cyc; e.lat = lat;
            q_wrap.push_back(e);
        end
    endtask

    function automatic op_t mk(input longint ar, ai, br, bi, cr, ci, input bit cj, sb,
                               input bit he, input longint er, ei, input bit eo);
        op_t o;
        o.a_re = ar; o.a_im = ai; o.b_re = br; o.b_im = bi; o.c_re = cr; o.c_im = ci;
        o.conj = cj; o.sub = sb; o.has_exp = he; o.e_re = er; o.e_im = ei; o.e_ovf = eo;
        return o;
    endfunction

    function automatic longint rv();
        case ($urandom_range(0, 7))
            0:       return -H;
            1:       return H - 1;
            default: return longint'($urandom_range(0, 32'(2 * H - 1))) - H;
        endcase
    endfunction

    op_t dir[$];
    op_t idle;
    bit  acc;

    task automatic drain();
        for (int i = 0; i < 40 && (q_sat.size() != 0 || q_wrap.size() != 0); i++)
            step(1'b0, idle, 1'b1, 1'b0, acc);
        chk("drain_sat", q_sat.size(), 0);
        chk("drain_wrap", q_wrap.size(), 0);
    endtask

    initial begin
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1; conj_i = 1'b0; sub_i = 1'b0;
        a_re_i = '0; a_im_i = '0; b_re_i = '0; b_im_i = '0; c_re_i = '0; c_im_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", s_valid, 0);
        chk("rst_ovf", s_ovf, 0);
        chk("rst_x_re", s_re, 0);
        chk("rst_x_im", s_im, 0);
        chk("rst_ready", s_ready, 1);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors with hand-derived saturating results
        dir.push_back(mk(0, 0, 16384, 0, 16384, 0, 0, 0, 1, 8192, 0, 0));
        dir.push_back(mk(0, 0, 16384, 16384, 16384, -16384, 0, 0, 1, 16384, 0, 0));
        dir.push_back(mk(0, 0, 16384, 16384, 16384, 16384, 1, 0, 1, 16384, 0, 0));
        dir.push_back(mk(0, 0, 16384, 16384, 16384, -16384, 1, 0, 1, 0, 16384, 0));
        dir.push_back(mk(16384, 0, 8192, 0, 16384, 0, 0, 1, 1, 12288, 0, 0));
        dir.push_back(mk(0, 0, 1, 0, 16384, 0, 0, 0, 1, 1, 0, 0));
        dir.push_back(mk(0, 0, -1, 0, 16384, 0, 0, 0, 1, 0, 0, 0));
        dir.push_back(mk(0, 0, -3, 0, 16384, 0, 0, 0, 1, -1, 0, 0));
        dir.push_back(mk(0, 0, 16384, 0, 0, -32768, 1, 0, 1, 0, 16384, 0));
        dir.push_back(mk(-32768, 0, -32768, 0, -32768, 0, 0, 0, 1, 0, 0, 0));
        dir.push_back(mk(16384, 0, -32768, 0, -32768, 0, 0, 0, 1, 32767, 0, 1));
        foreach (dir[i]) begin
            step(1'b1, dir[i], 1'b1, 1'b1, acc);
            chk("dir_accept", acc, 1);
        end
        drain();

        // Random stream under pseudorandom back-pressure and input bubbles
        for (int i = 0; i < 24; i++) begin
            op_t o;
            int  tries;
            o = mk(rv(), rv(), rv(), rv(), rv(), rv(), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 0, 0, 0, 0);
            if ($urandom_range(0, 3) == 0) step(1'b0, idle, 1'($urandom_range(0, 1)), 1'b0, acc);
            acc = 1'b0;
            tries = 0;
            while (!acc && tries < 100) begin
                step(1'b1, o, 1'($urandom_range(0, 1)), 1'b0, acc);
                tries++;
            end
            if (!acc) chk("accept_timeout", 0, 1);
        end
        drain();

        // Reset with three operand sets in flight
        for (int i = 0; i < 3; i++)
            step(1'b1, mk(0, 0, 16384, 0, 16384, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0, acc);
        @(negedge clk);
        rst = 1'b1; valid_i = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_valid", s_valid, 0);
        chk("midrst_ovf", s_ovf, 0);
        chk("midrst_x_re", s_re, 0);
        chk("midrst_ready", s_ready, 1);
        q_sat.delete();
        q_wrap.delete();
        s_held = 0;
        w_held = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) step(1'b0, idle, 1'b1, 1'b0, acc);
        step(1'b1, mk(100, -200, 16384, 16384, 16384, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b1, acc);
        chk("postrst_accept", acc, 1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
